// File: rtl/fib_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fib_sched_pkg : FSM state type and round-robin helper for the        |
// |                 Fibonacci request scheduler.        Revision: 1.0    |
// +----------------------------------------------------------------------+
package fib_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic int rr_next(input int cur, input int n);
    return (cur + 1 >= n) ? 0 : cur + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fib_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fib_core : Fibonacci stepping datapath (cur <= cur+prev, prev <= cur) |
// |            with carry-out of the addition.      Revision: 1.0        |
// +----------------------------------------------------------------------+
module fib_core #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  step,
  output logic [DATA_WIDTH-1:0] cur,
  output logic                  carry
);

  logic [DATA_WIDTH-1:0] cur_q;
  logic [DATA_WIDTH-1:0] prev_q;
  logic [DATA_WIDTH:0]   sum;

  assign sum = {1'b0, cur_q} + {1'b0, prev_q};

  // Cleared state is (F0, F(-1)) = (1, 0) so the first step yields F1 = 1.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cur_q  <= DATA_WIDTH'(1);
      prev_q <= '0;
    end else if (step) begin
      cur_q  <= sum[DATA_WIDTH-1:0];
      prev_q <= cur_q;
    end
  end

  assign cur   = cur_q;
  assign carry = sum[DATA_WIDTH];

endmodule
`default_nettype wire

// File: rtl/fib_req_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fib_req_scheduler : round-robin sharing of one Fibonacci datapath    |
// |                     among NUM_REQ requesters.     Revision: 1.0      |
// +----------------------------------------------------------------------+
module fib_req_scheduler
  import fib_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int IDX_WIDTH  = 6,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*IDX_WIDTH-1:0]   req_idx,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [ID_WIDTH-1:0]            resp_id,
  output logic [DATA_WIDTH-1:0]          resp_data,
  output logic                           resp_ovf
);

  state_e                state_q, state_d;
  logic [IDX_WIDTH-1:0]  cnt_q, cnt_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ID_WIDTH-1:0]   last_q, last_d;
  logic                  ovf_q, ovf_d;

  logic                  found;
  logic [ID_WIDTH-1:0]   win;
  logic [ID_WIDTH-1:0]   cand;
  logic [IDX_WIDTH-1:0]  sel_idx;
  logic                  core_clear, core_step, core_carry;
  logic [DATA_WIDTH-1:0] core_cur;

  // Search starts one past the last winner, so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = ID_WIDTH'(rr_next(int'(last_q), NUM_REQ));
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
      cand = ID_WIDTH'(rr_next(int'(cand), NUM_REQ));
    end
  end

  assign sel_idx = IDX_WIDTH'(req_idx >> (int'(win) * IDX_WIDTH));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    id_d       = id_q;
    last_d     = last_q;
    ovf_d      = ovf_q;
    core_clear = 1'b0;
    core_step  = 1'b0;
    req_ready  = '0;
    resp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (found && !reset) begin
          req_ready  = NUM_REQ'(1) << win;
          cnt_d      = sel_idx;
          id_d       = win;
          last_d     = win;
          ovf_d      = 1'b0;
          core_clear = 1'b1;
          state_d    = STEP;
        end
      end
      STEP: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          core_step = 1'b1;
          cnt_d     = cnt_q - IDX_WIDTH'(1);
          ovf_d     = ovf_q | core_carry;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      id_q    <= '0;
      last_q  <= ID_WIDTH'(NUM_REQ - 1);
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
    end
  end

  fib_core #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_core (
    .clk   (clk),
    .reset (reset),
    .clear (core_clear),
    .step  (core_step),
    .cur   (core_cur),
    .carry (core_carry)
  );

  assign resp_id   = id_q;
  assign resp_data = core_cur;
  assign resp_ovf  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_fib_req_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fib_req_scheduler : self-checking bench with transaction model.   |
// |                                                   Revision: 1.0      |
// +----------------------------------------------------------------------+
module tb_fib_req_scheduler;
  localparam int NR = 4;
  localparam int IW = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [NR-1:0]    req_valid, req_ready;
  logic [NR*IW-1:0] req_idx;
  logic             resp_valid, resp_ready, resp_ovf;
  logic [1:0]       resp_id;
  logic [31:0]      resp_data;

  logic [NR-1:0]    v8, rdy8;
  logic [NR*IW-1:0] i8;
  logic             rv8, rr8, o8;
  logic [1:0]       id8;
  logic [7:0]       d8;

  fib_req_scheduler #(.DATA_WIDTH(32), .NUM_REQ(NR), .IDX_WIDTH(IW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_idx(req_idx),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_data(resp_data), .resp_ovf(resp_ovf));

  fib_req_scheduler #(.DATA_WIDTH(8), .NUM_REQ(NR), .IDX_WIDTH(IW)) dut8 (
    .clk(clk), .reset(reset), .req_valid(v8), .req_idx(i8),
    .req_ready(rdy8), .resp_valid(rv8), .resp_ready(rr8),
    .resp_id(id8), .resp_data(d8), .resp_ovf(o8));

  int checks = 0;
  int passes = 0;
  bit pend[NR];
  int pidx[NR];
  int last_m;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // True (unbounded) term with F0 = F1 = 1; 64 bits holds every 6-bit index.
  function automatic longint unsigned fib_true(input int n);
    longint unsigned a = 1, b = 1, t;
    for (int k = 2; k <= n; k++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

  function automatic int rr_pick();
    for (int k = 1; k <= NR; k++)
      if (pend[(last_m + k) % NR]) return (last_m + k) % NR;
    return -1;
  endfunction

  task automatic add_req(input int r, input int n);
    req_valid[r] = 1'b1;
    req_idx[r*IW +: IW] = IW'(n);
    pend[r] = 1'b1;
    pidx[r] = n;
  endtask

  function automatic int rand_idx();
    return ($urandom_range(9) == 0) ? int'($urandom_range(63, 40)) : int'($urandom_range(15));
  endfunction

  task automatic maybe_add();
    int r;
    if ($urandom_range(3) == 0) begin
      r = int'($urandom_range(NR - 1));
      if (!pend[r]) add_req(r, rand_idx());
    end
  endtask

  // Called at a negedge with the DUT idle; ends at the negedge after the handshake.
  task automatic serve(input int hold, input bit rnd, input int add_r, input int add_n);
    int g, n;
    longint unsigned f;
    logic [31:0] d0;
    #1;
    g = rr_pick();
    if (g < 0) begin
      chk("no_pending_model", 0, 1);
      return;
    end
    chk("grant", req_ready, 64'(1) << g);
    resp_ready = (hold == 0);
    n = pidx[g];
    pend[g] = 1'b0;
    last_m = g;
    @(negedge clk);
    req_valid[g] = 1'b0;
    if (add_r >= 0) add_req(add_r, add_n);
    for (int c = 1; c < n + 2; c++) begin
      chk("busy", {resp_valid, req_ready}, 0);
      if (rnd) maybe_add();
      @(negedge clk);
    end
    f = fib_true(n);
    chk("resp_valid", resp_valid, 1);
    chk("resp_data", resp_data, f & 64'hFFFF_FFFF);
    chk("resp_id", resp_id, g);
    chk("resp_ovf", resp_ovf, (f >> 32) != 0);
    d0 = resp_data;
    for (int h = 0; h < hold; h++) begin
      if (rnd) maybe_add();
      @(negedge clk);
      chk("hold", {resp_valid, req_ready, resp_id, resp_data}, {1'b1, 4'b0, 2'(g), d0});
    end
    resp_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic serve8(input int n);
    int c;
    longint unsigned f;
    v8[0] = 1'b1;
    i8[IW-1:0] = IW'(n);
    rr8 = 1'b1;
    #1;
    chk("grant8", rdy8, 1);
    @(negedge clk);
    v8[0] = 1'b0;
    c = 1;
    while (!rv8 && c < 80) begin
      @(negedge clk);
      c++;
    end
    f = fib_true(n);
    chk("latency8", c, n + 2);
    chk("data8", d8, f & 64'hFF);
    chk("ovf8", o8, (f >> 8) != 0);
    chk("id8", id8, 0);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish (observed timeout, expected completion)");
    $fatal(1);
  end

  initial begin
    bit seen;
    req_valid = '0; req_idx = '0; resp_ready = 1'b1;
    v8 = '0; i8 = '0; rr8 = 1'b1;
    last_m = NR - 1;
    for (int i = 0; i < NR; i++) begin pend[i] = 1'b0; pidx[i] = 0; end

    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_valid", resp_valid, 0);
    chk("rst_id", resp_id, 0);
    chk("rst_ovf", resp_ovf, 0);
    chk("rst_data", resp_data, 1);
    reset = 1'b0;
    @(negedge clk);

    // idx 0, then requester 2 idx 10, then 32-bit overflow boundary
    add_req(0, 0);  serve(0, 0, -1, 0);
    add_req(2, 10); serve(0, 0, -1, 0);
    add_req(1, 46); serve(0, 0, -1, 0);
    add_req(3, 47); serve(1, 0, -1, 0);

    // 8-bit instance: wrap, overflow, and sticky flag cleared
    serve8(12);
    serve8(13);
    serve8(5);

    // all four at once, requester 0 re-asserting after its grant
    add_req(0, 1); add_req(1, 2); add_req(2, 3); add_req(3, 4);
    serve(0, 0, 0, 1);
    repeat (4) serve(0, 0, -1, 0);

    // backpressure with requester 1 waiting
    add_req(2, 6); serve(5, 0, 1, 2);
    serve(0, 0, -1, 0);

    // reset in the middle of a long request
    add_req(0, 20);
    #1;
    chk("rst_mid_grant", req_ready, 1);
    pend[0] = 1'b0;
    @(negedge clk);
    req_valid[0] = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    last_m = NR - 1;
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      seen |= resp_valid;
    end
    chk("no_stale_resp", seen, 0);
    add_req(2, 7); add_req(0, 3);
    serve(0, 0, -1, 0);
    serve(0, 0, -1, 0);

    // randomized traffic
    repeat (20) begin
      if (rr_pick() < 0) add_req(int'($urandom_range(NR - 1)), rand_idx());
      serve(int'($urandom_range(3)), 1'b1, -1, 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
